// File: rtl/lcd_decimal_writer.sv
// lcd_decimal_writer
//   Converts an unsigned binary value to a fixed-width ASCII decimal string
//   using shift-and-add-3 (one input bit per cycle). The string is streamed
//   most significant digit first into the LCD controller byte-write port, with
//   CHAR_GAP idle cycles after every character.
//
// Parameters
//   WIDTH     bit width of value (1..64)
//   DIGITS    decimal characters emitted (1..20)
//   CHAR_GAP  idle cycles after each character write (0..255)
//
// Ports
//   clock           system clock
//   resetn          asynchronous active-low reset
//   start           conversion request, sampled only in IDLE
//   value           binary input, latched when start is accepted
//   busy            high from the cycle after acceptance until done
//   done            one-cycle pulse after the last character's gap
//   overflow        value needed more than DIGITS digits; held until next accept
//   lcd_write_en    one-cycle strobe per character
//   lcd_write_data  ASCII character, holds its last value between strobes
//
// Build option
//   LCD_DECIMAL_WRITER_BLANK_EN  leading zeros are sent as spaces (0x20); the
//   least significant digit is always a numeral; no blanking on overflow.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; overflow from last run still visible
// S_CONVERT| WIDTH double-dabble steps, one input bit per cycle
// S_SEND   | lcd_write_en high for one character
// S_GAP    | CHAR_GAP idle cycles after a character
// S_FINISH | done pulse, busy already low

module lcd_decimal_writer #(
  parameter int WIDTH    = 32,
  parameter int DIGITS   = 10,
  parameter int CHAR_GAP = 3
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic             lcd_write_en,
  output logic [7:0]       lcd_write_data
);

  localparam int BCD_W = DIGITS * 4;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int IDX_W = $clog2(DIGITS + 1);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(DIGITS - 1);
  localparam logic [7:0]       GAP_LOAD = 8'(CHAR_GAP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONVERT,
    S_SEND,
    S_GAP,
    S_FINISH
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] bin;
  logic [BCD_W-1:0] bcd;
  logic [CNT_W-1:0] bit_cnt;
  logic [IDX_W-1:0] idx;
  logic [7:0]       gap_cnt;
  logic             ovf_flag;
`ifdef LCD_DECIMAL_WRITER_BLANK_EN
  logic             seen_nz;
`endif

  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] bcd_next;
  logic [WIDTH-1:0] bin_next;
  logic             ovf_next;

  logic             emit;
  logic [BCD_W-1:0] emit_bcd;
  logic [IDX_W-1:0] emit_idx;
  logic [3:0]       emit_nib;
  logic             blank;
  logic [7:0]       emit_char;

  // One double-dabble step: correct every nibble, then shift {bcd, bin}.
  // A 1 leaving the top nibble means the value does not fit in DIGITS digits.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
    end
    bcd_next = {bcd_adj[BCD_W-2:0], bin[WIDTH-1]};
    bin_next = bin << 1;
    ovf_next = ovf_flag | bcd_adj[BCD_W-1];
  end

  // A character is loaded on the edge that enters S_SEND so that the strobe
  // and its data are both registered. On the last conversion step the digits
  // come from the step's result rather than the (not yet updated) register.
  always_comb begin
    emit = ((state == S_CONVERT) && (bit_cnt == CNT_W'(1))) ||
           ((state == S_SEND) && (CHAR_GAP == 0) && (idx != '0)) ||
           ((state == S_GAP) && (gap_cnt == 8'd1) && (idx != '0));

    emit_bcd = (state == S_CONVERT) ? bcd_next : bcd;
    emit_idx = (state == S_CONVERT) ? IDX_TOP : (idx - IDX_W'(1));

    emit_nib = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (IDX_W'(i) == emit_idx) begin
        emit_nib = emit_bcd[i*4 +: 4];
      end
    end

    blank = 1'b0;
`ifdef LCD_DECIMAL_WRITER_BLANK_EN
    blank = !((state == S_CONVERT) ? ovf_next : ovf_flag) &&
            (emit_idx != '0) && (emit_nib == 4'd0) && !seen_nz;
`endif
    emit_char = blank ? 8'h20 : {4'h3, emit_nib};
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state          <= S_IDLE;
      bin            <= '0;
      bcd            <= '0;
      bit_cnt        <= '0;
      idx            <= '0;
      gap_cnt        <= '0;
      ovf_flag       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      overflow       <= 1'b0;
      lcd_write_en   <= 1'b0;
      lcd_write_data <= 8'h00;
`ifdef LCD_DECIMAL_WRITER_BLANK_EN
      seen_nz        <= 1'b0;
`endif
    end else begin
      lcd_write_en <= 1'b0;
      done         <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            bin      <= value;
            bcd      <= '0;
            ovf_flag <= 1'b0;
            overflow <= 1'b0;
            bit_cnt  <= CNT_LOAD;
            busy     <= 1'b1;
`ifdef LCD_DECIMAL_WRITER_BLANK_EN
            seen_nz  <= 1'b0;
`endif
            state    <= S_CONVERT;
          end
        end

        S_CONVERT: begin
          bin      <= bin_next;
          bcd      <= bcd_next;
          ovf_flag <= ovf_next;
          bit_cnt  <= bit_cnt - CNT_W'(1);
          if (bit_cnt == CNT_W'(1)) begin
            state <= S_SEND;
          end
        end

        S_SEND: begin
          if (CHAR_GAP != 0) begin
            gap_cnt <= GAP_LOAD;
            state   <= S_GAP;
          end else if (idx == '0) begin
            done     <= 1'b1;
            busy     <= 1'b0;
            overflow <= ovf_flag;
            state    <= S_FINISH;
          end
        end

        S_GAP: begin
          if (gap_cnt == 8'd1) begin
            if (idx == '0) begin
              done     <= 1'b1;
              busy     <= 1'b0;
              overflow <= ovf_flag;
              state    <= S_FINISH;
            end else begin
              state <= S_SEND;
            end
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end

        S_FINISH: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase

      if (emit) begin
        idx            <= emit_idx;
        lcd_write_en   <= 1'b1;
        lcd_write_data <= emit_char;
`ifdef LCD_DECIMAL_WRITER_BLANK_EN
        seen_nz        <= seen_nz | (emit_nib != 4'd0);
`endif
      end
    end
  end

endmodule

// File: tb/tb_lcd_decimal_writer.sv
// Testbench for lcd_decimal_writer. Two instances: the default configuration
// (32-bit, 10 digits, gap 3) and a narrow one (16-bit, 4 digits, gap 0) that
// exercises overflow and back-to-back strobes. Expected strings come from
// plain decimal arithmetic on the requested value.

module tb_lcd_decimal_writer;

  localparam int PW[2] = '{32, 16};
  localparam int PD[2] = '{10, 4};
  localparam int PG[2] = '{3, 0};

  logic        clock;
  logic        resetn;
  logic        start_s[2];
  logic [63:0] val_s[2];
  logic        busy_s[2];
  logic        done_s[2];
  logic        ovf_s[2];
  logic        en_s[2];
  logic [7:0]  data_s[2];

  int total_cnt = 0;
  int bad_cnt   = 0;
  int cyc       = 0;

  logic [7:0] q_data[2][$];
  int         q_cyc[2][$];
  int         done_cnt[2];
  int         done_cyc[2];
  logic       ovf_done[2];
  logic       busy_done[2];

  lcd_decimal_writer #(.WIDTH(32), .DIGITS(10), .CHAR_GAP(3)) u_dut0 (
    .clock          (clock),
    .resetn         (resetn),
    .start          (start_s[0]),
    .value          (val_s[0][31:0]),
    .busy           (busy_s[0]),
    .done           (done_s[0]),
    .overflow       (ovf_s[0]),
    .lcd_write_en   (en_s[0]),
    .lcd_write_data (data_s[0])
  );

  lcd_decimal_writer #(.WIDTH(16), .DIGITS(4), .CHAR_GAP(0)) u_dut1 (
    .clock          (clock),
    .resetn         (resetn),
    .start          (start_s[1]),
    .value          (val_s[1][15:0]),
    .busy           (busy_s[1]),
    .done           (done_s[1]),
    .overflow       (ovf_s[1]),
    .lcd_write_en   (en_s[1]),
    .lcd_write_data (data_s[1])
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (en_s[i]) begin
        q_data[i].push_back(data_s[i]);
        q_cyc[i].push_back(cyc);
      end
      if (done_s[i]) begin
        done_cnt[i]  = done_cnt[i] + 1;
        done_cyc[i]  = cyc;
        ovf_done[i]  = ovf_s[i];
        busy_done[i] = busy_s[i];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic longint unsigned pow10(input int n);
    longint unsigned p = 1;
    for (int k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

  // Runs one transaction on instance i. poke: loop cycle at which a stray
  // start (value 123) is raised for one cycle. rst_at: loop cycle at which
  // reset is asserted, aborting the transaction.
  task automatic run(input int i, input longint unsigned v_in, input int poke, input int rst_at);
    int w, d, g, acc, total;
    longint unsigned v, m, dig;
    logic exp_ovf, lead;
    logic [7:0] exp_ch[$];

    w = PW[i]; d = PD[i]; g = PG[i];
    v = v_in & ((64'd1 << w) - 64'd1);
    total = w + d * (g + 1);

    @(negedge clock);
    q_data[i].delete();
    q_cyc[i].delete();
    done_cnt[i] = 0;
    val_s[i]    = v;
    start_s[i]  = 1'b1;
    @(negedge clock);
    start_s[i] = 1'b0;
    acc = cyc;
    val_s[i] = {$urandom, $urandom};
    chk("busy_after_accept", busy_s[i], 1'b1);

    for (int n = 1; n <= total + 4; n++) begin
      @(negedge clock);
      if (n == poke) begin
        start_s[i] = 1'b1;
        val_s[i]   = 64'd123;
      end else begin
        start_s[i] = 1'b0;
      end
      if (n == rst_at) begin
        resetn = 1'b0;
        #1;
        chk("rst_busy", busy_s[i], 1'b0);
        chk("rst_done", done_s[i], 1'b0);
        chk("rst_ovf",  ovf_s[i],  1'b0);
        chk("rst_en",   en_s[i],   1'b0);
        chk("rst_data", data_s[i], 8'h00);
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        repeat (total) @(negedge clock);
        chk("rst_strobes_stopped", q_data[i].size(), 3);
        chk("rst_no_done", done_cnt[i], 0);
        return;
      end
    end

    m = v % pow10(d);
    exp_ovf = (v >= pow10(d));
`ifdef LCD_DECIMAL_WRITER_BLANK_EN
    lead = !exp_ovf;
`else
    lead = 1'b0;
`endif
    for (int k = 0; k < d; k++) begin
      dig = (m / pow10(d - 1 - k)) % 10;
      if (lead && dig == 0 && k != d - 1) begin
        exp_ch.push_back(8'h20);
      end else begin
        exp_ch.push_back(8'h30 + 8'(dig));
        lead = 1'b0;
      end
    end

    chk("strobe_count", q_data[i].size(), d);
    for (int k = 0; k < d && k < q_data[i].size(); k++) begin
      chk($sformatf("char%0d", k), q_data[i][k], exp_ch[k]);
      chk($sformatf("strobe_cyc%0d", k), q_cyc[i][k], acc + w + k * (g + 1));
    end
    chk("done_count", done_cnt[i], 1);
    chk("done_cyc", done_cyc[i], acc + total);
    chk("busy_at_done", busy_done[i], 1'b0);
    chk("ovf_at_done", ovf_done[i], exp_ovf);
    @(negedge clock);
    chk("ovf_held_idle", ovf_s[i], exp_ovf);
    chk("busy_idle", busy_s[i], 1'b0);
    chk("data_held", data_s[i], exp_ch[d-1]);
  endtask

  initial begin
    resetn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_s[i]  = 1'b0;
      val_s[i]    = '0;
      done_cnt[i] = 0;
      done_cyc[i] = 0;
      ovf_done[i] = 1'b0;
      busy_done[i] = 1'b0;
    end
    repeat (3) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      chk("reset_busy", busy_s[i], 1'b0);
      chk("reset_done", done_s[i], 1'b0);
      chk("reset_en",   en_s[i],   1'b0);
      chk("reset_data", data_s[i], 8'h00);
      chk("reset_ovf",  ovf_s[i],  1'b0);
    end
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    run(0, 64'd56876, 0, 0);
    run(0, 64'hFFFF_FFFF, 0, 0);
    run(0, 64'd0, 0, 0);
    run(0, 64'($urandom), 45, 0);
    run(0, 64'd1234567890, 0, 42);
    run(0, 64'd56876, 0, 0);
    for (int r = 0; r < 4; r++) run(0, 64'($urandom), 0, 0);

    run(1, 64'd56876, 0, 0);
    run(1, 64'd9999, 0, 0);
    run(1, 64'd0, 0, 0);
    run(1, 64'd10000, 18, 0);
    for (int r = 0; r < 4; r++) run(1, 64'($urandom_range(0, 65535)), 0, 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
